// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic instruction requests into 32-bit MIPS machine
// words and presents them one per output handshake at an auto-incrementing PC.
// The LI pseudo-op expands to one or two words depending on its immediate.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT1 = 2'd1;
  localparam logic [1:0] EMIT2 = 2'd2;

  localparam logic [5:0] OP_NOP     = 6'd0;
  localparam logic [5:0] OP_ADD     = 6'd1;
  localparam logic [5:0] OP_SUB     = 6'd2;
  localparam logic [5:0] OP_AND     = 6'd3;
  localparam logic [5:0] OP_OR      = 6'd4;
  localparam logic [5:0] OP_SLT     = 6'd5;
  localparam logic [5:0] OP_SLTU    = 6'd6;
  localparam logic [5:0] OP_MULT    = 6'd7;
  localparam logic [5:0] OP_MULTU   = 6'd8;
  localparam logic [5:0] OP_DIV     = 6'd9;
  localparam logic [5:0] OP_DIVU    = 6'd10;
  localparam logic [5:0] OP_MFHI    = 6'd11;
  localparam logic [5:0] OP_MFLO    = 6'd12;
  localparam logic [5:0] OP_MTHI    = 6'd13;
  localparam logic [5:0] OP_MTLO    = 6'd14;
  localparam logic [5:0] OP_JR      = 6'd15;
  localparam logic [5:0] OP_SYSCALL = 6'd16;
  localparam logic [5:0] OP_MFC0    = 6'd17;
  localparam logic [5:0] OP_MTC0    = 6'd18;
  localparam logic [5:0] OP_ERET    = 6'd19;
  localparam logic [5:0] OP_ADDI    = 6'd20;
  localparam logic [5:0] OP_ANDI    = 6'd21;
  localparam logic [5:0] OP_ORI     = 6'd22;
  localparam logic [5:0] OP_LUI     = 6'd23;
  localparam logic [5:0] OP_LW      = 6'd24;
  localparam logic [5:0] OP_LH      = 6'd25;
  localparam logic [5:0] OP_LB      = 6'd26;
  localparam logic [5:0] OP_SW      = 6'd27;
  localparam logic [5:0] OP_SH      = 6'd28;
  localparam logic [5:0] OP_SB      = 6'd29;
  localparam logic [5:0] OP_BEQ     = 6'd30;
  localparam logic [5:0] OP_BNE     = 6'd31;
  localparam logic [5:0] OP_JAL     = 6'd32;
  localparam logic [5:0] OP_LI      = 6'd33;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_COP0    = 6'h10;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;

  logic [1:0]  state;
  logic [31:0] pend_instr;
  logic        pend_two;

  logic        legal;
  logic        two_word;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [15:0] imm_hi;
  logic [15:0] imm_lo;

  assign in_ready = (state == IDLE);
  assign imm_hi   = in_imm[31:16];
  assign imm_lo   = in_imm[15:0];

  // Encode the current request; unused fields and shamt are held at zero.
  always_comb begin
    legal    = 1'b1;
    two_word = 1'b0;
    word1    = '0;
    word2    = '0;
    case (in_op)
      OP_NOP:     word1 = '0;
      OP_ADD:     word1 = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      OP_SUB:     word1 = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      OP_AND:     word1 = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      OP_OR:      word1 = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      OP_SLT:     word1 = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      OP_SLTU:    word1 = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'd0, 6'h2B};
      OP_MULT:    word1 = {OPC_SPECIAL, in_rs, in_rt, 10'd0, 6'h18};
      OP_MULTU:   word1 = {OPC_SPECIAL, in_rs, in_rt, 10'd0, 6'h19};
      OP_DIV:     word1 = {OPC_SPECIAL, in_rs, in_rt, 10'd0, 6'h1A};
      OP_DIVU:    word1 = {OPC_SPECIAL, in_rs, in_rt, 10'd0, 6'h1B};
      OP_MFHI:    word1 = {OPC_SPECIAL, 10'd0, in_rd, 5'd0, 6'h10};
      OP_MFLO:    word1 = {OPC_SPECIAL, 10'd0, in_rd, 5'd0, 6'h12};
      OP_MTHI:    word1 = {OPC_SPECIAL, in_rs, 15'd0, 6'h11};
      OP_MTLO:    word1 = {OPC_SPECIAL, in_rs, 15'd0, 6'h13};
      OP_JR:      word1 = {OPC_SPECIAL, in_rs, 15'd0, 6'h08};
      OP_SYSCALL: word1 = 32'h0000_000C;
      OP_MFC0:    word1 = {OPC_COP0, 5'b00000, in_rt, in_rd, 11'd0};
      OP_MTC0:    word1 = {OPC_COP0, 5'b00100, in_rt, in_rd, 11'd0};
      OP_ERET:    word1 = 32'h4200_0018;
      OP_ADDI:    word1 = {6'h08, in_rs, in_rt, imm_lo};
      OP_ANDI:    word1 = {6'h0C, in_rs, in_rt, imm_lo};
      OP_ORI:     word1 = {OPC_ORI, in_rs, in_rt, imm_lo};
      OP_LUI:     word1 = {OPC_LUI, 5'd0, in_rt, imm_lo};
      OP_LW:      word1 = {6'h23, in_rs, in_rt, imm_lo};
      OP_LH:      word1 = {6'h21, in_rs, in_rt, imm_lo};
      OP_LB:      word1 = {6'h20, in_rs, in_rt, imm_lo};
      OP_SW:      word1 = {6'h2B, in_rs, in_rt, imm_lo};
      OP_SH:      word1 = {6'h29, in_rs, in_rt, imm_lo};
      OP_SB:      word1 = {6'h28, in_rs, in_rt, imm_lo};
      OP_BEQ:     word1 = {6'h04, in_rs, in_rt, imm_lo};
      OP_BNE:     word1 = {6'h05, in_rs, in_rt, imm_lo};
      OP_JAL:     word1 = {6'h03, in_imm[25:0]};
      OP_LI: begin
        // Small values need only ORI, low-half-zero values only LUI;
        // everything else is LUI followed by ORI into the same register.
        if (imm_hi == 16'd0) begin
          word1 = {OPC_ORI, 5'd0, in_rt, imm_lo};
        end else if (imm_lo == 16'd0) begin
          word1 = {OPC_LUI, 5'd0, in_rt, imm_hi};
        end else begin
          word1    = {OPC_LUI, 5'd0, in_rt, imm_hi};
          word2    = {OPC_ORI, in_rt, in_rt, imm_lo};
          two_word = 1'b1;
        end
      end
      default:    legal = 1'b0;
    endcase
  end

  // Request acceptance, output handshake sequencing and PC advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= BASE_ADDR;
      err        <= 1'b0;
      pend_instr <= '0;
      pend_two   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              out_instr  <= word1;
              pend_instr <= word2;
              pend_two   <= two_word;
              out_valid  <= 1'b1;
              state      <= EMIT1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EMIT1: begin
          if (out_ready) begin
            out_addr <= out_addr + 32'd4;
            if (pend_two) begin
              out_instr <= pend_instr;
              state     <= EMIT2;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        EMIT2: begin
          if (out_ready) begin
            out_addr  <= out_addr + 32'd4;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed spot checks plus randomized requests
// compared cycle by cycle against a queue-based model of the emitted stream.
module tb_instr_encoder;

  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam logic [31:0] BASE_W = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_out_instr, w_out_addr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        rnd = 1'b0;

  logic [31:0] mq[$];
  logic [31:0] exp_addr = BASE;
  logic        exp_err  = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err)
  );

  // Second instance starting near the top of the address space to exercise wrap.
  instr_encoder #(.BASE_ADDR(BASE_W)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
    .out_addr(w_out_addr), .err(w_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rw(input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic [5:0] fn);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] iw(input logic [5:0] o, input logic [4:0] s,
                                     input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  // Reference: words a request expands to; returns word count, 0 = illegal.
  function automatic int model_words(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [31:0] imm,
                                     output logic [31:0] w0, output logic [31:0] w1);
    logic [15:0] hi, lo;
    int cnt;
    hi  = 16'(imm >> 16);
    lo  = 16'(imm & 32'hFFFF);
    w0  = '0;
    w1  = '0;
    cnt = 1;
    case (op)
      0:  w0 = 32'h0;
      1:  w0 = rw(rs, rt, rd, 6'h20);
      2:  w0 = rw(rs, rt, rd, 6'h22);
      3:  w0 = rw(rs, rt, rd, 6'h24);
      4:  w0 = rw(rs, rt, rd, 6'h25);
      5:  w0 = rw(rs, rt, rd, 6'h2A);
      6:  w0 = rw(rs, rt, rd, 6'h2B);
      7:  w0 = rw(rs, rt, 5'd0, 6'h18);
      8:  w0 = rw(rs, rt, 5'd0, 6'h19);
      9:  w0 = rw(rs, rt, 5'd0, 6'h1A);
      10: w0 = rw(rs, rt, 5'd0, 6'h1B);
      11: w0 = rw(5'd0, 5'd0, rd, 6'h10);
      12: w0 = rw(5'd0, 5'd0, rd, 6'h12);
      13: w0 = rw(rs, 5'd0, 5'd0, 6'h11);
      14: w0 = rw(rs, 5'd0, 5'd0, 6'h13);
      15: w0 = rw(rs, 5'd0, 5'd0, 6'h08);
      16: w0 = 32'h0000_000C;
      17: w0 = (32'h10 << 26) | (32'(rt) << 16) | (32'(rd) << 11);
      18: w0 = (32'h10 << 26) | (32'h4 << 21) | (32'(rt) << 16) | (32'(rd) << 11);
      19: w0 = 32'h4200_0018;
      20: w0 = iw(6'h08, rs, rt, lo);
      21: w0 = iw(6'h0C, rs, rt, lo);
      22: w0 = iw(6'h0D, rs, rt, lo);
      23: w0 = iw(6'h0F, 5'd0, rt, lo);
      24: w0 = iw(6'h23, rs, rt, lo);
      25: w0 = iw(6'h21, rs, rt, lo);
      26: w0 = iw(6'h20, rs, rt, lo);
      27: w0 = iw(6'h2B, rs, rt, lo);
      28: w0 = iw(6'h29, rs, rt, lo);
      29: w0 = iw(6'h28, rs, rt, lo);
      30: w0 = iw(6'h04, rs, rt, lo);
      31: w0 = iw(6'h05, rs, rt, lo);
      32: w0 = (32'h03 << 26) | (imm & 32'h03FF_FFFF);
      33: begin
        if (hi == 0)      w0 = iw(6'h0D, 5'd0, rt, lo);
        else if (lo == 0) w0 = iw(6'h0F, 5'd0, rt, hi);
        else begin
          w0  = iw(6'h0F, 5'd0, rt, hi);
          w1  = iw(6'h0D, rt, rt, lo);
          cnt = 2;
        end
      end
      default: cnt = 0;
    endcase
    return cnt;
  endfunction

  // Model update at each active edge: accept when empty, else retire on handshake.
  always @(posedge clk) begin
    logic [31:0] a, b;
    int cnt;
    if (reset) begin
      exp_err = 1'b0;
      if (mq.size() == 0) begin
        if (in_valid) begin
          cnt = model_words(in_op, in_rs, in_rt, in_rd, in_imm, a, b);
          if (cnt == 0) exp_err = 1'b1;
          if (cnt >= 1) mq.push_back(a);
          if (cnt == 2) mq.push_back(b);
        end
      end else if (out_ready) begin
        void'(mq.pop_front());
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  always @(negedge reset) begin
    mq.delete();
    exp_addr = BASE;
    exp_err  = 1'b0;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("in_ready", 32'(in_ready), 32'(mq.size() == 0));
      check("err", 32'(err), 32'(exp_err));
      check("out_addr", out_addr, exp_addr);
      check("wrap_addr", w_out_addr, exp_addr + (BASE_W - BASE));
      if (mq.size() != 0) check("out_instr", out_instr, mq[0]);
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm);
    int unsigned n = 0;
    while (!in_ready) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        check("send_timeout", 32'(n), 32'd0);
        return;
      end
    end
    in_valid = 1'b1;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op  = 6'($urandom);
    in_rs  = 5'($urandom);
    in_rt  = 5'($urandom);
    in_rd  = 5'($urandom);
    in_imm = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", n_checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    int cnt;
    logic [5:0]  op;
    logic [31:0] imm;

    // Model pins against hand-encoded words.
    cnt = model_words(6'd1, 5'd1, 5'd2, 5'd3, 32'd0, a, b);
    check("model_add", a, 32'h0022_1820);
    cnt = model_words(6'd33, 5'd0, 5'd8, 5'd0, 32'h1234_5678, a, b);
    check("model_li_cnt", 32'(cnt), 32'd2);
    check("model_li_w1", b, 32'h3508_5678);
    cnt = model_words(6'd18, 5'd0, 5'd9, 5'd12, 32'd0, a, b);
    check("model_mtc0", a, 32'h4089_6000);

    // Reset state.
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", out_addr, 32'h0000_3000);
    check("rst_instr", out_instr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ADD with one-cycle latency.
    out_ready = 1'b1;
    send(6'd1, 5'd1, 5'd2, 5'd3, 32'd0);
    check("add_instr", out_instr, 32'h0022_1820);
    check("add_addr", out_addr, 32'h0000_3000);
    check("add_valid", 32'(out_valid), 32'd1);

    // Two-word LI.
    do_reset();
    send(6'd33, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    check("li2_w0", out_instr, 32'h3C08_1234);
    check("li2_a0", out_addr, 32'h0000_3000);
    check("li2_rdy0", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("li2_w1", out_instr, 32'h3508_5678);
    check("li2_a1", out_addr, 32'h0000_3004);
    check("li2_rdy1", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("li2_done", 32'(out_valid), 32'd0);

    // Single-word LI forms.
    send(6'd33, 5'd0, 5'd8, 5'd0, 32'h0000_00FF);
    check("li_ori", out_instr, 32'h3408_00FF);
    @(posedge clk); #1;
    check("li_ori_single", 32'(out_valid), 32'd0);
    send(6'd33, 5'd0, 5'd8, 5'd0, 32'hABCD_0000);
    check("li_lui", out_instr, 32'h3C08_ABCD);
    @(posedge clk); #1;
    check("li_lui_single", 32'(out_valid), 32'd0);

    // SW with back-pressure.
    do_reset();
    out_ready = 1'b0;
    send(6'd27, 5'd29, 5'd2, 5'd0, 32'h0000_FFFC);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("sw_hold_instr", out_instr, 32'hAFA2_FFFC);
      check("sw_hold_addr", out_addr, 32'h0000_3000);
      check("sw_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("sw_addr_after", out_addr, 32'h0000_3004);

    // Illegal op.
    do_reset();
    send(6'h3F, 5'd0, 5'd0, 5'd0, 32'd0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("ill_err_pulse", 32'(err), 32'd0);
    send(6'd1, 5'd1, 5'd2, 5'd3, 32'd0);
    check("ill_next_addr", out_addr, 32'h0000_3000);

    // Reset during the second LI word.
    do_reset();
    send(6'd33, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_addr", out_addr, 32'h0000_3000);
    check("rst2_instr", out_instr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    send(6'd19, 5'd0, 5'd0, 5'd0, 32'd0);
    check("eret", out_instr, 32'h4200_0018);
    check("eret_addr", out_addr, 32'h0000_3000);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure.
    rnd = 1'b1;
    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(34, 63)) : 6'($urandom_range(0, 33));
      imm = $urandom;
      case ($urandom_range(0, 4))
        0: imm = imm & 32'h0000_FFFF;
        1: imm = imm & 32'hFFFF_0000;
        2: imm = 32'd0;
        default: ;
      endcase
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), imm);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
